// File: rtl/kanagawa_race_counter_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : KanagawaTypes (package)
// Brief   : Shared types for the race-counter reader: FSM state and beat record.
// Revision: 1.0 - initial release
// ============================================================================
package KanagawaTypes;

    localparam int RCR_NUM_COUNTERS  = 4;
    localparam int RCR_COUNTER_WIDTH = 8;
    localparam int RCR_INDEX_WIDTH   = (RCR_NUM_COUNTERS > 1) ? $clog2(RCR_NUM_COUNTERS) : 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } reader_state_e;

    typedef struct packed {
        logic [RCR_INDEX_WIDTH-1:0]   index;
        logic [RCR_COUNTER_WIDTH-1:0] delta;
        logic                         last;
    } rsp_beat_t;

    // A single counter still needs a one-bit index port.
    function automatic int index_width(input int num_counters);
        return (num_counters > 1) ? $clog2(num_counters) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kanagawa_race_counter_reader_delta_slice.sv
`default_nettype none
// ============================================================================
// Module  : kanagawa_race_delta_slice
// Brief   : Per-counter snapshot register and modulo delta since last capture.
// Revision: 1.0 - initial release
// ============================================================================
module kanagawa_race_delta_slice
    import KanagawaTypes::*;
#(
    parameter int COUNTER_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     capture_i,
    input  logic [COUNTER_WIDTH-1:0] count_i,
    output logic [COUNTER_WIDTH-1:0] delta_o
);

    logic [COUNTER_WIDTH-1:0] prev_q;
    logic [COUNTER_WIDTH-1:0] prev_d;
    logic [COUNTER_WIDTH-1:0] delta_q;
    logic [COUNTER_WIDTH-1:0] delta_d;

    // Natural wrap of the subtraction gives the modulo-2^W increment.
    always_comb begin
        prev_d  = prev_q;
        delta_d = delta_q;
        if (capture_i) begin
            prev_d  = count_i;
            delta_d = count_i - prev_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= '0;
            delta_q <= '0;
        end else begin
            prev_q  <= prev_d;
            delta_q <= delta_d;
        end
    end

    assign delta_o = delta_q;

endmodule
`default_nettype wire

// File: rtl/kanagawa_race_counter_reader.sv
`default_nettype none
// ============================================================================
// Module  : kanagawa_race_counter_reader
// Brief   : Coherent snapshot of the race counters, streamed as per-counter deltas.
// Revision: 1.0 - initial release
// ============================================================================
module kanagawa_race_counter_reader
    import KanagawaTypes::*;
#(
    parameter  int NUM_COUNTERS  = 4,
    parameter  int COUNTER_WIDTH = 8,
    localparam int INDEX_WIDTH   = index_width(NUM_COUNTERS)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_COUNTERS*COUNTER_WIDTH-1:0] counts_in,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [INDEX_WIDTH-1:0]                rsp_index,
    output logic [COUNTER_WIDTH-1:0]              rsp_delta,
    output logic                                  rsp_last
);

    localparam logic [INDEX_WIDTH-1:0] c_LAST_IDX = INDEX_WIDTH'(NUM_COUNTERS - 1);

    reader_state_e            state_q;
    logic [INDEX_WIDTH-1:0]   idx_q;
    logic                     rsp_valid_q;
    logic                     rsp_last_q;
    logic                     w_capture;
    logic [INDEX_WIDTH-1:0]   w_idx_next;
    logic [COUNTER_WIDTH-1:0] w_delta [NUM_COUNTERS];
    logic [COUNTER_WIDTH-1:0] w_rsp_delta;

    assign req_ready  = !rst && (state_q == ST_IDLE);
    assign w_capture  = req_valid && req_ready;
    assign w_idx_next = idx_q + INDEX_WIDTH'(1);

    // Every slice shares one strobe, so all counters are sampled on the same edge.
    generate
        for (genvar gi = 0; gi < NUM_COUNTERS; gi++) begin : g_slice
            kanagawa_race_delta_slice #(
                .COUNTER_WIDTH (COUNTER_WIDTH)
            ) u_slice (
                .clk       (clk),
                .rst       (rst),
                .capture_i (w_capture),
                .count_i   (counts_in[gi*COUNTER_WIDTH +: COUNTER_WIDTH]),
                .delta_o   (w_delta[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        state_q     <= ST_STREAM;
                        idx_q       <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_last_q  <= (c_LAST_IDX == '0);
                    end
                end
                ST_STREAM: begin
                    if (rsp_ready) begin
                        if (rsp_last_q) begin
                            state_q     <= ST_IDLE;
                            idx_q       <= '0;
                            rsp_valid_q <= 1'b0;
                            rsp_last_q  <= 1'b0;
                        end else begin
                            idx_q      <= w_idx_next;
                            rsp_last_q <= (w_idx_next == c_LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    idx_q       <= '0;
                    rsp_valid_q <= 1'b0;
                    rsp_last_q  <= 1'b0;
                end
            endcase
        end
    end

    // Delta selection depends only on registered state; zero outside a beat.
    always_comb begin
        w_rsp_delta = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (rsp_valid_q && (idx_q == INDEX_WIDTH'(i))) begin
                w_rsp_delta = w_delta[i];
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_index = idx_q;
    assign rsp_delta = w_rsp_delta;
    assign rsp_last  = rsp_last_q;

endmodule
`default_nettype wire

// File: tb/tb_kanagawa_race_counter_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_kanagawa_race_counter_reader
// Brief   : Directed vector bench for the race-counter reader (4x8 and 1x4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_kanagawa_race_counter_reader;

    logic        clk;
    logic        rst;
    logic [31:0] counts_in;
    logic        req_valid;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_index;
    logic [7:0]  rsp_delta;
    logic        rsp_last;

    logic        rst2;
    logic [3:0]  counts2;
    logic        req_valid2;
    logic        req_ready2;
    logic        rsp_valid2;
    logic        rsp_ready2;
    logic [0:0]  rsp_index2;
    logic [3:0]  rsp_delta2;
    logic        rsp_last2;

    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "init";

    kanagawa_race_counter_reader #(
        .NUM_COUNTERS  (4),
        .COUNTER_WIDTH (8)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .counts_in (counts_in),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_index (rsp_index),
        .rsp_delta (rsp_delta),
        .rsp_last  (rsp_last)
    );

    kanagawa_race_counter_reader #(
        .NUM_COUNTERS  (1),
        .COUNTER_WIDTH (4)
    ) u_dut1 (
        .clk       (clk),
        .rst       (rst2),
        .counts_in (counts2),
        .req_valid (req_valid2),
        .req_ready (req_ready2),
        .rsp_valid (rsp_valid2),
        .rsp_ready (rsp_ready2),
        .rsp_index (rsp_index2),
        .rsp_delta (rsp_delta2),
        .rsp_last  (rsp_last2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rv;
        logic        rr;
        logic        full;
        logic [31:0] counts;
        logic        erq;
        logic        ev;
        logic [1:0]  eidx;
        logic [7:0]  ed;
        logic        el;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] pk(input int c0, input int c1, input int c2, input int c3);
        logic [31:0] r;
        r = {c3[7:0], c2[7:0], c1[7:0], c0[7:0]};
        return r;
    endfunction

    function automatic vec_t mk(input int rs, input int rv, input int rr, input int full,
                                input logic [31:0] cnt, input int erq, input int ev,
                                input int eidx, input int ed, input int el);
        vec_t v;
        v.rst = rs[0];   v.rv = rv[0];   v.rr = rr[0];   v.full = full[0];
        v.counts = cnt;  v.erq = erq[0]; v.ev = ev[0];
        v.eidx = eidx[1:0]; v.ed = ed[7:0]; v.el = el[0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL [%s] %s t=%0t: got 0x%0h, expected 0x%0h", phase, nm, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs, compare the outputs seen in that cycle, advance.
    task automatic cyc(input vec_t v);
        rst       = v.rst;
        req_valid = v.rv;
        rsp_ready = v.rr;
        counts_in = v.counts;
        #1;
        chk("req_ready", 32'(req_ready), 32'(v.erq));
        chk("rsp_valid", 32'(rsp_valid), 32'(v.ev));
        if (v.ev || v.full) begin
            chk("rsp_index", 32'(rsp_index), 32'(v.eidx));
            chk("rsp_delta", 32'(rsp_delta), 32'(v.ed));
            chk("rsp_last",  32'(rsp_last),  32'(v.el));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc2(input int rs, input int rv, input int rr, input int cnt,
                        input int erq, input int ev, input int ed, input int el);
        rst2       = rs[0];
        req_valid2 = rv[0];
        rsp_ready2 = rr[0];
        counts2    = cnt[3:0];
        #1;
        chk("n1_req_ready", 32'(req_ready2), 32'(erq[0]));
        chk("n1_rsp_valid", 32'(rsp_valid2), 32'(ev[0]));
        if (ev != 0) begin
            chk("n1_rsp_index", 32'(rsp_index2), 32'd0);
            chk("n1_rsp_delta", 32'(rsp_delta2), 32'(ed[3:0]));
            chk("n1_rsp_last",  32'(rsp_last2),  32'(el[0]));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1; counts_in = '0;
        rst2 = 1'b1; req_valid2 = 1'b0; rsp_ready2 = 1'b1; counts2 = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset, first read, wrapping read, then back-to-back reads with req_valid held.
        vecs.push_back(mk(1,0,1,1, pk(0,0,0,0),     0,0,0,0,0));
        vecs.push_back(mk(0,0,1,0, pk(3,0,7,255),   1,0,0,0,0));
        vecs.push_back(mk(0,1,1,0, pk(3,0,7,255),   1,0,0,0,0));
        vecs.push_back(mk(0,0,1,0, pk(3,0,7,255),   0,1,0,3,0));
        vecs.push_back(mk(0,0,1,0, pk(3,0,7,255),   0,1,1,0,0));
        vecs.push_back(mk(0,0,1,0, pk(3,0,7,255),   0,1,2,7,0));
        vecs.push_back(mk(0,0,1,0, pk(3,0,7,255),   0,1,3,255,1));
        vecs.push_back(mk(0,0,1,0, pk(5,0,7,4),     1,0,0,0,0));
        vecs.push_back(mk(0,1,1,0, pk(5,0,7,4),     1,0,0,0,0));
        vecs.push_back(mk(0,1,1,0, pk(5,0,7,4),     0,1,0,2,0));
        vecs.push_back(mk(0,1,1,0, pk(5,0,7,4),     0,1,1,0,0));
        vecs.push_back(mk(0,1,1,0, pk(5,0,7,4),     0,1,2,0,0));
        vecs.push_back(mk(0,1,1,0, pk(5,0,7,4),     0,1,3,5,1));
        vecs.push_back(mk(0,1,1,0, pk(5,0,7,4),     1,0,0,0,0));
        vecs.push_back(mk(0,1,1,0, pk(5,0,7,4),     0,1,0,0,0));
        vecs.push_back(mk(0,1,1,0, pk(5,0,7,4),     0,1,1,0,0));
        vecs.push_back(mk(0,1,1,0, pk(5,0,7,4),     0,1,2,0,0));
        vecs.push_back(mk(0,1,1,0, pk(5,0,7,4),     0,1,3,0,1));
        vecs.push_back(mk(0,0,1,0, pk(5,0,7,4),     1,0,0,0,0));

        phase = "table";
        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i]);
        end

        // Consumer stalls on beat 1 while the counters keep moving.
        phase = "stall";
        cyc(mk(0,1,1,0, pk(10,20,30,40), 1,0,0,0,0));
        cyc(mk(0,0,1,0, pk(10,20,30,40), 0,1,0,5,0));
        for (int k = 0; k < 3; k++) begin
            cyc(mk(0,0,0,0, pk(11+k,22+k,33+k,44+k), 0,1,1,20,0));
        end
        cyc(mk(0,0,1,0, pk(12,25,35,50), 0,1,1,20,0));
        cyc(mk(0,0,1,0, pk(12,25,35,50), 0,1,2,23,0));
        cyc(mk(0,0,1,0, pk(12,25,35,50), 0,1,3,36,1));
        cyc(mk(0,0,1,0, pk(12,25,35,50), 1,0,0,0,0));
        phase = "after_stall";
        cyc(mk(0,1,1,0, pk(12,25,35,50), 1,0,0,0,0));
        cyc(mk(0,0,1,0, pk(12,25,35,50), 0,1,0,2,0));
        cyc(mk(0,0,1,0, pk(12,25,35,50), 0,1,1,5,0));
        cyc(mk(0,0,1,0, pk(12,25,35,50), 0,1,2,5,0));
        cyc(mk(0,0,1,0, pk(12,25,35,50), 0,1,3,10,1));
        cyc(mk(0,0,1,0, pk(12,25,35,50), 1,0,0,0,0));

        // Reset lands mid-stream after beat 1 was accepted.
        phase = "midreset";
        cyc(mk(0,1,1,0, pk(13,27,38,54), 1,0,0,0,0));
        cyc(mk(0,0,1,0, pk(13,27,38,54), 0,1,0,1,0));
        cyc(mk(0,0,1,0, pk(13,27,38,54), 0,1,1,2,0));
        cyc(mk(1,0,1,0, pk(13,27,38,54), 0,1,2,3,0));
        cyc(mk(1,0,1,1, pk(0,0,0,0),     0,0,0,0,0));
        cyc(mk(0,0,1,1, pk(0,0,0,0),     1,0,0,0,0));
        cyc(mk(0,1,1,0, pk(1,2,3,4),     1,0,0,0,0));
        cyc(mk(0,0,1,0, pk(1,2,3,4),     0,1,0,1,0));
        cyc(mk(0,0,1,0, pk(1,2,3,4),     0,1,1,2,0));
        cyc(mk(0,0,1,0, pk(1,2,3,4),     0,1,2,3,0));
        cyc(mk(0,0,1,0, pk(1,2,3,4),     0,1,3,4,1));
        cyc(mk(0,0,1,0, pk(1,2,3,4),     1,0,0,0,0));

        // Single 4-bit counter: one beat per read, wrap 15 -> 2 reports 3.
        phase = "single";
        cyc2(1,0,1,0,  0,0,0,0);
        cyc2(0,0,1,15, 1,0,0,0);
        cyc2(0,1,1,15, 1,0,0,0);
        cyc2(0,0,1,15, 0,1,15,1);
        cyc2(0,0,1,2,  1,0,0,0);
        cyc2(0,1,1,2,  1,0,0,0);
        cyc2(0,0,1,2,  0,1,3,1);
        cyc2(0,0,1,2,  1,0,0,0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
